// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : control FSM encoding (IDLE, RUN, DONE), 2 bits.
//   cnt_width : width of the bit counter for a given operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow-out bout.
// Ports:
//   x, y  : minuend / subtrahend bits
//   bin   : borrow in
//   d     : difference bit
//   bout  : borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first,
// through a single full_subtractor cell. An accepted start launches
// WIDTH RUN cycles followed by a one-cycle DONE pulse; diff/borrow are
// held until the next operation completes (or reset).
// Optional feature macro: SERIAL_SUB_SIGNED_OVF_EN adds the ovf output
// (two's-complement overflow of a - b), updated together with diff.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   start   : request pulse, sampled only in IDLE
//   a, b    : minuend / subtrahend, captured on the accepted start edge
//   busy    : high in RUN
//   done    : one-cycle pulse when diff/borrow are valid
//   diff    : (a - b) mod 2^WIDTH
//   borrow  : 1 iff unsigned a < b
//   ovf     : (macro only) signed overflow of a - b
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  output logic             borrow,
  output logic             ovf
`else
  output logic             borrow
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

  full_subtractor u_cell (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .bin  (bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Serial datapath: operand shifters, result shifter, borrow chain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a <= a;
            sh_b <= b;
            cnt  <= '0;
            bin  <= 1'b0;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= {cell_d, res[WIDTH-1:1]};
          bin  <= cell_bout;
          cnt  <= cnt + CW'(1);
          // The final bit is merged in directly so diff lands on the
          // RUN->DONE edge without an extra cycle.
          if (last_bit) begin
            diff   <= {cell_d, res[WIDTH-1:1]};
            borrow <= cell_bout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  // On the last RUN step the cell sees the operand MSBs, and cell_d is
  // the result MSB, so overflow is resolved in the same pass.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf <= (sh_a[0] ^ sh_b[0]) & (cell_d ^ sh_a[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH = 4). The driver pushes
// the expected {borrow, diff} (and ovf when SERIAL_SUB_SIGNED_OVF_EN is
// defined) when a start is accepted; the monitor pops and compares on
// every done pulse.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic         borrow;
    logic [W-1:0] diff;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;
  int done_exp  = 0;
  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    .borrow  (borrow),
    .ovf     (ovf)
`else
    .borrow  (borrow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y};
    e.borrow = r[W];
    e.diff   = r[W-1:0];
    e.ovf    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return e;
  endfunction

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (reset_n && done) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("diff",   32'(diff),   32'(e.diff));
        check("borrow", 32'(borrow), 32'(e.borrow));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check("ovf",    32'(ovf),    32'(e.ovf));
`endif
      end
    end
  end

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_timeout", 32'(seen), 32'd1);
  endtask

  // Start raised just after edge 0, accepted at edge 1; busy must read
  // high after edges 1-4 and done after edge 5 only.
  task automatic run_timed(input logic [W-1:0] x, input logic [W-1:0] y, input bit inject);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_q.push_back(model(x, y));
    done_exp++;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      if (inject && e == 1) begin
        a = 4'h1; b = 4'h1; start = 1'b1;
      end
      if (inject && e == 2) start = 1'b0;
    end
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done",  32'(busy), 32'd0);
    @(negedge clk);
    check("done_single", 32'(done), 32'd0);
    check("busy_idle",   32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_q.push_back(model(x, y));
    done_exp++;
    wait_done();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_diff",   32'(diff),   32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    check("rst_ovf",    32'(ovf),    32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    // Latency and handshake, plus a start injected while busy
    run_timed(4'h9, 4'h3, 1'b0);
    run_timed(4'h9, 4'h3, 1'b1);

    // Directed boundaries
    run_op(4'h3, 4'h9);
    run_op(4'h0, 4'h1);
    run_op(4'hF, 4'hF);
    run_op(4'h8, 4'h1);
    run_op(4'h5, 4'h2);
    run_op(4'h0, 4'h0);
    run_op(4'hF, 4'h0);
    run_op(4'h7, 4'h8);

    // Start held during the done cycle: not taken on the DONE->IDLE
    // edge, taken on the next one.
    run_op(4'hC, 4'h4);
    a = 4'hA; b = 4'h5; start = 1'b1;
    @(posedge clk);
    #1 check("start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk);
    #1 check("start_after_done", 32'(busy), 32'd1);
    start = 1'b0;
    exp_q.push_back(model(4'hA, 4'h5));
    done_exp++;
    wait_done();

    // Reset during the second RUN cycle aborts the operation
    @(negedge clk);
    a = 4'hD; b = 4'h2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_diff",   32'(diff),   32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", 32'(done_seen), 32'(done_exp));
    run_timed(4'h2, 4'h6, 1'b0);

    // Back-to-back random operands
    for (int i = 0; i < 150; i++) begin
      run_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    check("done_count",  32'(done_seen), 32'(done_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
